// File: rtl/avalon_led_ctrl_pkg.sv
// avalon_led_ctrl_pkg: shared address map and address width for the LED/GPIO output slave
package avalon_led_ctrl_pkg;
    localparam int ADDR_W = 3;
    localparam logic [ADDR_W-1:0] ADDR_DATA   = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_MODE   = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_OUTSET = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_OUTCLR = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 3'd5;
endpackage

// File: rtl/led_blink_timer.sv
// led_blink_timer: shared blink phase generator, phase toggles every period+1 clocks
// Ports: clk, reset_n (async, active-low), period (reload value, already muxed with a
// same-cycle PERIOD write), load (PERIOD write strobe, restarts the phase high), ph (phase).
module led_blink_timer #(
    parameter int PRESC_W = 24,
    parameter logic [31:0] RESET_PERIOD = 32'd2_499_999
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [PRESC_W-1:0] period,
    input  logic               load,
    output logic               ph
);
    logic [PRESC_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            cnt <= RESET_PERIOD[PRESC_W-1:0];
            ph  <= 1'b1;
        end else if (load) begin
            cnt <= period;
            ph  <= 1'b1;
        end else if (period == '0) begin
            ph  <= 1'b1;
        end else if (cnt == '0) begin
            cnt <= period;
            ph  <= ~ph;
        end else begin
            cnt <= cnt - 1'b1;
        end
endmodule

// File: rtl/avalon_led_ctrl.sv
// avalon_led_ctrl: zero-wait Avalon-MM output PIO with set/clear and optional blink engine
// Ports: clk, reset_n (async, active-low), address/chipselect/write_n/writedata (slave
// write side), readdata (combinational read mux), out_port (board output lines).
// Build option: define AVALON_LED_CTRL_BLINK_EN to add MODE/PERIOD registers and the blink timer.
module avalon_led_ctrl
    import avalon_led_ctrl_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int PRESC_W = 24,
    parameter logic [31:0] RESET_PERIOD = 32'd2_499_999
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [WIDTH-1:0]  out_port
);
    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data;
    logic             unused_bits;

    assign wr = chipselect & ~write_n;
    assign wd = writedata[WIDTH-1:0];
    assign unused_bits = ^{writedata, RESET_PERIOD, PRESC_W};

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            data <= '0;
        else if (wr)
            data <= address == ADDR_DATA   ? wd :
                    address == ADDR_OUTSET ? data | wd :
                    address == ADDR_OUTCLR ? data & ~wd : data;

`ifdef AVALON_LED_CTRL_BLINK_EN
    logic [WIDTH-1:0]   mode;
    logic [PRESC_W-1:0] period;
    logic               wr_period;
    logic               ph;

    assign wr_period = wr && address == ADDR_PERIOD;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            mode   <= '0;
            period <= RESET_PERIOD[PRESC_W-1:0];
        end else begin
            if (wr && address == ADDR_MODE)
                mode <= wd;
            if (wr_period)
                period <= writedata[PRESC_W-1:0];
        end

    // The timer sees the incoming value on a PERIOD write so the reload happens on that edge.
    led_blink_timer #(.PRESC_W(PRESC_W), .RESET_PERIOD(RESET_PERIOD)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .period  (wr_period ? writedata[PRESC_W-1:0] : period),
        .load    (wr_period),
        .ph      (ph)
    );

    assign out_port = data & (~mode | {WIDTH{ph}});
`else
    assign out_port = data;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata[WIDTH-1:0] = data;
`ifdef AVALON_LED_CTRL_BLINK_EN
            ADDR_MODE:   readdata[WIDTH-1:0] = mode;
            ADDR_PERIOD: readdata[PRESC_W-1:0] = period;
`endif
            ADDR_STATUS: readdata[WIDTH-1:0] = out_port;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_avalon_led_ctrl.sv
// tb_avalon_led_ctrl: directed self-checking bench for avalon_led_ctrl
module tb_avalon_led_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [9:0]  out_port;
    int n_cmp = 0;
    int n_err = 0;

    avalon_led_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a;
        writedata = d;
        chipselect = 1'b1;
        write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
        address = a;
        chipselect = 1'b1;
        #1;
        chk(tag, readdata, exp);
        chipselect = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        chk("por_out", {22'd0, out_port}, 32'h0);
        wr(3'd0, 32'h3FF);
        chk("pre_rst_out", {22'd0, out_port}, 32'h3FF);
        #2 reset_n = 1'b0;
        #1 chk("async_rst_out", {22'd0, out_port}, 32'h0);
        rd(3'd0, 32'h0, "rst_data");
        rd(3'd1, 32'h0, "rst_mode");
`ifdef AVALON_LED_CTRL_BLINK_EN
        rd(3'd2, 32'd2_499_999, "rst_period");
`else
        rd(3'd2, 32'h0, "rst_period");
`endif
        @(negedge clk);
        reset_n = 1'b1;

        wr(3'd0, 32'h03FF_F0F0);
        rd(3'd0, 32'h0F0, "data_trunc");
        chk("data_out", {22'd0, out_port}, 32'h0F0);
        wr(3'd3, 32'h00F);
        chk("outset_out", {22'd0, out_port}, 32'h0FF);
        wr(3'd4, 32'h0F0);
        chk("outclr_out", {22'd0, out_port}, 32'h00F);
        rd(3'd3, 32'h0, "outset_rd");
        rd(3'd4, 32'h0, "outclr_rd");
        rd(3'd5, 32'h00F, "status_rd");

        wr(3'd6, 32'hFFFF_FFFF);
        rd(3'd0, 32'h00F, "rsvd_wr_data");
        rd(3'd1, 32'h0, "rsvd_wr_mode");
        rd(3'd6, 32'h0, "rsvd6_rd");
        rd(3'd7, 32'h0, "rsvd7_rd");
        @(negedge clk);
        address = 3'd0;
        writedata = 32'h3FF;
        chipselect = 1'b0;
        write_n = 1'b0;
        @(negedge clk);
        write_n = 1'b1;
        rd(3'd0, 32'h00F, "cs0_ignored");

`ifdef AVALON_LED_CTRL_BLINK_EN
        wr(3'd0, 32'h3FF);
        wr(3'd1, 32'h005);
        rd(3'd1, 32'h005, "mode_rd");
        wr(3'd2, 32'd3);
        rd(3'd2, 32'd3, "period_rd");
        for (int k = 0; k < 20; k++) begin
            logic [31:0] e;
            e = ((k / 4) % 2 == 0) ? 32'h3FF : 32'h3FA;
            chk($sformatf("blink_out_%0d", k), {22'd0, out_port}, e);
            rd(3'd5, e, $sformatf("blink_status_%0d", k));
            @(negedge clk);
        end
        chk("pre_restart_ph0", {22'd0, out_port}, 32'h3FA);
        wr(3'd2, 32'd5);
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("restart_out_%0d", k), {22'd0, out_port},
                ((k / 6) % 2 == 0) ? 32'h3FF : 32'h3FA);
            @(negedge clk);
        end
        wr(3'd1, 32'h3FF);
        wr(3'd0, 32'h2AA);
        wr(3'd2, 32'd0);
        for (int k = 0; k < 100; k++) begin
            chk($sformatf("p0_out_%0d", k), {22'd0, out_port}, 32'h2AA);
            @(negedge clk);
        end
        wr(3'd2, 32'd1);
        repeat (2) @(negedge clk);
        chk("midblink_ph0", {22'd0, out_port}, 32'h0);
        #2 reset_n = 1'b0;
        #1 chk("midblink_rst_out", {22'd0, out_port}, 32'h0);
        rd(3'd1, 32'h0, "midblink_rst_mode");
        rd(3'd2, 32'd2_499_999, "midblink_rst_period");
        @(negedge clk);
        reset_n = 1'b1;
`else
        wr(3'd1, 32'h3FF);
        wr(3'd2, 32'd7);
        rd(3'd1, 32'h0, "nomacro_mode");
        rd(3'd2, 32'h0, "nomacro_period");
        wr(3'd0, 32'h155);
        chk("nomacro_out", {22'd0, out_port}, 32'h155);
        rd(3'd5, 32'h155, "nomacro_status");
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
